// File: rtl/prbs31_checker.sv
// Parallel PRBS31 (x^31+x^28+1) bit-error checker. It synchronises to the incoming
// stream by itself and then counts bit errors per word. Define PRBS_ERR_ACCUM_EN to add the err_total output.
module prbs31_checker #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned LOSS_CNT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] prbs,
    output logic             lock,
    output logic [WIDTH:0]   err_num
`ifdef PRBS_ERR_ACCUM_EN
    ,
    output logic [31:0]      err_total
`endif
);

    localparam int unsigned FILL = (31 + WIDTH - 1) / WIDTH;
    localparam int unsigned CW   = 8;
    localparam int unsigned FW   = 6;
    localparam int unsigned EW   = WIDTH + 1;

    localparam logic [CW-1:0] LOCK_LIM = CW'(LOCK_CNT);
    localparam logic [CW-1:0] LOSS_LIM = CW'(LOSS_CNT);
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [FW-1:0] FILL_LIM = FW'(FILL);

    typedef enum logic {
        S_UNLOCKED = 1'b0,
        S_LOCKED   = 1'b1
    } state_t;

    state_t          state, state_nx;
    logic [30:0]     hist, hist_nx;
    logic [30:0]     ref_lfsr, ref_lfsr_nx;
    logic [FW-1:0]   fill, fill_nx;
    logic [CW-1:0]   match_cnt, match_cnt_nx;
    logic [CW-1:0]   err_cnt, err_cnt_nx;
    logic            lock_nx;
    logic [EW-1:0]   err_num_nx;
    logic [WIDTH-1:0] pred_c;
    logic [EW-1:0]   err_c;

    // Next WIDTH sequence bits from a 31-bit window (bit 0 newest); MSB of result is earliest.
    function automatic logic [WIDTH-1:0] predict(input logic [30:0] s);
        logic [WIDTH-1:0] p;
        p = '0;
        for (int j = 0; j < int'(WIDTH); j++) begin
            p[WIDTH-1-j] = s[30-j] ^ s[27-j];
        end
        return p;
    endfunction

    function automatic logic [30:0] shift_in(input logic [30:0] s, input logic [WIDTH-1:0] w);
        return {s[30-WIDTH:0], w};
    endfunction

    function automatic logic [EW-1:0] popcount(input logic [WIDTH-1:0] x);
        logic [EW-1:0] c;
        c = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            c = c + EW'(x[i]);
        end
        return c;
    endfunction

    assign pred_c = predict((state == S_LOCKED) ? ref_lfsr : hist);
    assign err_c  = popcount(prbs ^ pred_c);

    // Lock acquisition/loss and per-word error accounting.
    always_comb begin
        state_nx     = state;
        hist_nx      = hist;
        ref_lfsr_nx  = ref_lfsr;
        fill_nx      = fill;
        match_cnt_nx = match_cnt;
        err_cnt_nx   = err_cnt;
        err_num_nx   = '0;
        if (en) begin
            hist_nx = shift_in(hist, prbs);
            case (state)
                S_UNLOCKED: begin
                    if (fill < FILL_LIM) begin
                        fill_nx = fill + FW'(1);
                    end else begin
                        // An all-zero history predicts all zeros and must never lock.
                        if ((pred_c == prbs) && (hist != '0)) begin
                            match_cnt_nx = (match_cnt == CNT_MAX) ? CNT_MAX : match_cnt + CW'(1);
                        end else begin
                            match_cnt_nx = '0;
                        end
                        if (match_cnt_nx == LOCK_LIM) begin
                            state_nx    = S_LOCKED;
                            ref_lfsr_nx = hist_nx;
                        end
                    end
                end
                S_LOCKED: begin
                    ref_lfsr_nx = shift_in(ref_lfsr, pred_c);
                    err_num_nx  = err_c;
                    if (err_c != '0) begin
                        err_cnt_nx = (err_cnt == CNT_MAX) ? CNT_MAX : err_cnt + CW'(1);
                    end else begin
                        err_cnt_nx = '0;
                    end
                    if (err_cnt_nx == LOSS_LIM) begin
                        state_nx     = S_UNLOCKED;
                        match_cnt_nx = '0;
                        err_cnt_nx   = '0;
                    end
                end
                default: state_nx = S_UNLOCKED;
            endcase
        end
    end

    assign lock_nx = (state_nx == S_LOCKED);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_UNLOCKED;
            hist      <= '0;
            ref_lfsr  <= '0;
            fill      <= '0;
            match_cnt <= '0;
            err_cnt   <= '0;
            lock      <= 1'b0;
            err_num   <= '0;
        end else begin
            state     <= state_nx;
            hist      <= hist_nx;
            ref_lfsr  <= ref_lfsr_nx;
            fill      <= fill_nx;
            match_cnt <= match_cnt_nx;
            err_cnt   <= err_cnt_nx;
            lock      <= lock_nx;
            err_num   <= err_num_nx;
        end
    end

`ifdef PRBS_ERR_ACCUM_EN
    logic [31:0] err_total_nx;
    logic [32:0] sum_c;

    // Saturating running total, restarted whenever lock is (re)acquired.
    always_comb begin
        sum_c        = {1'b0, err_total} + 33'(err_num_nx);
        err_total_nx = sum_c[32] ? 32'hFFFF_FFFF : sum_c[31:0];
        if ((state == S_UNLOCKED) && (state_nx == S_LOCKED)) begin
            err_total_nx = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_total <= '0;
        end else begin
            err_total <= err_total_nx;
        end
    end
`endif

endmodule

// File: tb/tb_prbs31_checker.sv
// Randomised self-checking bench for prbs31_checker against a bit-queue reference model.
module tb_prbs31_checker;

    localparam int unsigned W    = 8;
    localparam int unsigned LOCK = 4;
    localparam int unsigned LOSS = 4;
    localparam int unsigned F    = (31 + W - 1) / W;

    logic         clk;
    logic         reset;
    logic         en;
    logic [W-1:0] prbs;
    logic         lock;
    logic [W:0]   err_num;
`ifdef PRBS_ERR_ACCUM_EN
    logic [31:0]  err_total;
`endif

    prbs31_checker #(
        .WIDTH    (W),
        .LOCK_CNT (LOCK),
        .LOSS_CNT (LOSS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .prbs     (prbs),
        .lock     (lock),
        .err_num  (err_num)
`ifdef PRBS_ERR_ACCUM_EN
        ,
        .err_total(err_total)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Generator: last 31 sequence bits, index 0 oldest.
    bit gen_q[$];

    // Reference model state.
    bit     m_hist[$];
    bit     m_ref[$];
    int     m_fill, m_match, m_errc, m_err_num;
    bit     m_lock;
    longint m_total;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_word(output logic [W-1:0] w);
        bit nb;
        w = '0;
        for (int j = 0; j < int'(W); j++) begin
            nb = gen_q[0] ^ gen_q[3];
            gen_q.push_back(nb);
            void'(gen_q.pop_front());
            w[W-1-j] = nb;
        end
    endtask

    task automatic model_reset();
        m_hist = {};
        m_ref  = {};
        for (int i = 0; i < 31; i++) begin
            m_hist.push_back(1'b0);
            m_ref.push_back(1'b0);
        end
        m_fill = 0; m_match = 0; m_errc = 0; m_err_num = 0; m_lock = 0; m_total = 0;
    endtask

    // One clock of behaviour from the sequence rules: recurrence over bit lists.
    task automatic model_step(input bit r, input bit e, input logic [W-1:0] w);
        bit t[$];
        bit nb, ok, nz, acq;
        int errs;
        acq = 0;
        if (r) begin
            model_reset();
            return;
        end
        m_err_num = 0;
        if (e) begin
            if (!m_lock) begin
                if (m_fill < int'(F)) begin
                    m_fill++;
                end else begin
                    t = m_hist; ok = 1; nz = 0;
                    foreach (m_hist[i]) if (m_hist[i]) nz = 1;
                    for (int j = 0; j < int'(W); j++) begin
                        nb = t[0] ^ t[3];
                        t.push_back(nb);
                        void'(t.pop_front());
                        if (nb != w[W-1-j]) ok = 0;
                    end
                    m_match = (ok && nz) ? ((m_match < 255) ? m_match + 1 : 255) : 0;
                    if (m_match == int'(LOCK)) acq = 1;
                end
            end else begin
                errs = 0;
                for (int j = 0; j < int'(W); j++) begin
                    nb = m_ref[0] ^ m_ref[3];
                    m_ref.push_back(nb);
                    void'(m_ref.pop_front());
                    if (nb != w[W-1-j]) errs++;
                end
                m_err_num = errs;
                m_errc = (errs != 0) ? ((m_errc < 255) ? m_errc + 1 : 255) : 0;
                if (m_errc == int'(LOSS)) begin
                    m_lock = 0; m_match = 0; m_errc = 0;
                end
            end
            for (int j = 0; j < int'(W); j++) begin
                m_hist.push_back(w[W-1-j]);
                void'(m_hist.pop_front());
            end
            if (acq) begin
                m_lock = 1;
                m_ref  = m_hist;
            end
        end
        if (acq) m_total = 0;
        else begin
            m_total = m_total + longint'(m_err_num);
            if (m_total > 64'hFFFF_FFFF) m_total = 64'hFFFF_FFFF;
        end
    endtask

    // Apply one cycle of inputs, advance the model, compare after the edge.
    task automatic cycle(input bit r, input bit e, input logic [W-1:0] w, input string tag);
        reset = r; en = e; prbs = w;
        model_step(r, e, w);
        @(posedge clk);
        #1;
        check({tag, ".lock"}, 64'(lock), 64'(m_lock));
        check({tag, ".err_num"}, 64'(err_num), 64'(m_err_num));
`ifdef PRBS_ERR_ACCUM_EN
        check({tag, ".err_total"}, 64'(err_total), 64'(m_total));
`endif
    endtask

    initial begin
        logic [W-1:0] w;
        bit seen_lock;
        int inv_left;

        clk = 0; reset = 1; en = 0; prbs = '0;
        for (int i = 0; i < 31; i++) gen_q.push_back(1'($urandom_range(1, 0)));
        gen_q[30] = 1'b1;
        model_reset();

        // Reset held for two cycles.
        for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, '0, "reset");
        check("reset_lock", 64'(lock), 64'd0);
        check("reset_err", 64'(err_num), 64'd0);

        // Clean stream: lock exactly at edge F+LOCK.
        for (int k = 1; k <= 20; k++) begin
            next_word(w);
            cycle(1'b0, 1'b1, w, "clean");
            if (k == int'(F + LOCK) - 1) check("lock_before", 64'(lock), 64'd0);
            if (k == int'(F + LOCK)) check("lock_at_edge", 64'(lock), 64'd1);
        end

        // Enable gaps hold lock, err_num stays zero.
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, '0, "gap");
        for (int i = 0; i < 5; i++) begin
            next_word(w);
            cycle(1'b0, 1'b1, w, "resume");
        end
        check("gap_lock", 64'(lock), 64'd1);

        // Single bit flip: one cycle of err_num=1.
        next_word(w);
        w = w ^ (W'(1) << $urandom_range(W - 1, 0));
        cycle(1'b0, 1'b1, w, "flip");
        check("flip_err1", 64'(err_num), 64'd1);
        next_word(w);
        cycle(1'b0, 1'b1, w, "flip_after");
        check("flip_err0", 64'(err_num), 64'd0);
        check("flip_lock", 64'(lock), 64'd1);

        // Four inverted words drop lock.
        for (int i = 0; i < int'(LOSS); i++) begin
            next_word(w);
            cycle(1'b0, 1'b1, ~w, "invert");
            check("invert_err", 64'(err_num), 64'(W));
        end
        check("loss_lock", 64'(lock), 64'd0);
        for (int i = 0; i < 16; i++) begin
            next_word(w);
            cycle(1'b0, 1'b1, w, "relock");
        end
        check("relock_lock", 64'(lock), 64'd1);

        // All-zero input never locks.
        cycle(1'b1, 1'b0, '0, "zero_rst");
        seen_lock = 0;
        for (int i = 0; i < 100; i++) begin
            cycle(1'b0, 1'b1, '0, "zero");
            if (lock) seen_lock = 1;
        end
        check("zero_never_lock", 64'(seen_lock), 64'd0);

        // Random enables, bit flips, inverted bursts and occasional resets.
        inv_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(499, 0) == 0) begin
                cycle(1'b1, 1'b0, '0, "rnd_rst");
            end else if ($urandom_range(3, 0) == 0) begin
                cycle(1'b0, 1'b0, W'($urandom), "rnd_idle");
            end else begin
                next_word(w);
                if (inv_left > 0) begin
                    w = ~w;
                    inv_left--;
                end else if ($urandom_range(149, 0) == 0) begin
                    inv_left = $urandom_range(6, 2);
                end else if ($urandom_range(7, 0) == 0) begin
                    w = w ^ (W'(1) << $urandom_range(W - 1, 0));
                end
                cycle(1'b0, 1'b1, w, "rnd");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
